// File: rtl/gpio_pkg.sv
// Shared definitions for the multi-port GPIO block: register offsets,
// the per-port register view and the register read selector.
package gpio_pkg;

  localparam int MAX_W = 8;

  localparam logic [2:0] REG_DATA  = 3'd0;
  localparam logic [2:0] REG_DDR   = 3'd1;
  localparam logic [2:0] REG_IEN   = 3'd2;
  localparam logic [2:0] REG_IPOL  = 3'd3;
  localparam logic [2:0] REG_IFLAG = 3'd4;

  // Fields are sized for the widest supported port; narrower ports zero-extend.
  typedef struct packed {
    logic [MAX_W-1:0] data;
    logic [MAX_W-1:0] ddr;
    logic [MAX_W-1:0] ien;
    logic [MAX_W-1:0] ipol;
    logic [MAX_W-1:0] iflag;
  } port_regs_t;

  function automatic logic [MAX_W-1:0] reg_read(input port_regs_t r, input logic [2:0] off);
    logic [MAX_W-1:0] val;
    case (off)
      REG_DATA:  val = r.data;
      REG_DDR:   val = r.ddr;
      REG_IEN:   val = r.ien;
      REG_IPOL:  val = r.ipol;
      REG_IFLAG: val = r.iflag;
      default:   val = '0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/gpio_edge_detect.sv
// Per-pin edge detector with selectable polarity and sticky write-1-to-clear
// flags; a newly detected edge overrides a clear in the same cycle.
module gpio_edge_detect
  import gpio_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] eff,
  input  logic [WIDTH-1:0] prev,
  input  logic [WIDTH-1:0] ipol,
  input  logic [WIDTH-1:0] ien,
  input  logic [WIDTH-1:0] clr,
  output logic [WIDTH-1:0] iflag
);

  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] hit;

  always_comb begin
    rise = eff & ~prev;
    fall = ~eff & prev;
    hit  = ien & ((ipol & rise) | (~ipol & fall));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      iflag <= '0;
    end else begin
      iflag <= (iflag & ~clr) | hit;
    end
  end

endmodule

// File: rtl/gpio_multiport.sv
// NPORTS x WIDTH bidirectional GPIO with per-port data/direction registers,
// synchronised inputs, edge-triggered sticky interrupt flags and irq_n.
module gpio_multiport
  import gpio_pkg::*;
#(
  parameter int NPORTS = 2,
  parameter int WIDTH  = 8,
  parameter int AW     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cs,
  input  logic                    we_n,
  input  logic [AW-1:0]           A,
  input  logic [WIDTH-1:0]        DI,
  output logic [WIDTH-1:0]        DO,
  output logic                    OE,
  input  logic [NPORTS*WIDTH-1:0] pin_in,
  output logic [NPORTS*WIDTH-1:0] pin_out,
  output logic [NPORTS*WIDTH-1:0] ddr,
  output logic                    irq_n
);

  localparam int IDXW = AW - 3;

  logic [IDXW-1:0]                idx;
  logic [2:0]                     off;
  logic                           wr_en;
  logic                           rd_en;
  logic [NPORTS-1:0]              irq_src;
  port_regs_t [NPORTS-1:0]        view;
  logic [MAX_W-1:0]               rd_val;

  assign idx   = A[AW-1:3];
  assign off   = A[2:0];
  assign wr_en = cs & ~we_n;
  assign rd_en = cs & we_n;

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    logic             hit;
    logic [WIDTH-1:0] data_r;
    logic [WIDTH-1:0] ddr_r;
    logic [WIDTH-1:0] ien_r;
    logic [WIDTH-1:0] ipol_r;
    logic [WIDTH-1:0] sync_p0;
    logic [WIDTH-1:0] sync_p1;
    logic [WIDTH-1:0] eff;
    logic [WIDTH-1:0] prev_r;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] iflag;

    assign hit = wr_en && (idx == IDXW'(p));

    always_ff @(posedge clk) begin
      if (rst) begin
        data_r  <= '0;
        ddr_r   <= '0;
        ien_r   <= '0;
        ipol_r  <= '0;
        sync_p0 <= '0;
        sync_p1 <= '0;
        prev_r  <= '0;
      end else begin
        // stage p0/p1: two-flop synchroniser on the raw pads
        sync_p0 <= pin_in[p*WIDTH +: WIDTH];
        sync_p1 <= sync_p0;
        prev_r  <= eff;
        if (hit) begin
          case (off)
            REG_DATA: data_r <= DI;
            REG_DDR:  ddr_r  <= DI;
            REG_IEN:  ien_r  <= DI;
            REG_IPOL: ipol_r <= DI;
            default:  ;
          endcase
        end
      end
    end

    // Output pins see their own driven value, so writes to DATA can self-trigger.
    assign eff = (ddr_r & data_r) | (~ddr_r & sync_p1);
    assign clr = (hit && off == REG_IFLAG) ? DI : '0;

    gpio_edge_detect #(.WIDTH(WIDTH)) u_edge (
      .clk   (clk),
      .rst   (rst),
      .eff   (eff),
      .prev  (prev_r),
      .ipol  (ipol_r),
      .ien   (ien_r),
      .clr   (clr),
      .iflag (iflag)
    );

    assign irq_src[p]                = |(iflag & ien_r);
    assign pin_out[p*WIDTH +: WIDTH] = data_r;
    assign ddr[p*WIDTH +: WIDTH]     = ddr_r;
    assign view[p] = '{data:  MAX_W'(eff),
                       ddr:   MAX_W'(ddr_r),
                       ien:   MAX_W'(ien_r),
                       ipol:  MAX_W'(ipol_r),
                       iflag: MAX_W'(iflag)};
  end

  // Out-of-range port indices match no port and read as zero.
  always_comb begin
    rd_val = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (idx == IDXW'(p)) begin
        rd_val = reg_read(view[p], off);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      DO <= '0;
      OE <= 1'b0;
    end else begin
      // stage p2: registered bus read
      OE <= rd_en;
      if (rd_en) begin
        DO <= rd_val[WIDTH-1:0];
      end
    end
  end

  assign irq_n = ~|irq_src;

endmodule

// File: tb/tb_gpio_multiport.sv
// Bench for gpio_multiport: directed scenarios plus random bus/pad traffic
// compared every cycle against a behavioural model of the register block.
module tb_gpio_multiport;

  localparam int NP  = 2;
  localparam int W   = 8;
  localparam int AWB = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic           cs;
  logic           we_n;
  logic [AWB-1:0] A;
  logic [W-1:0]   DI;
  logic [W-1:0]   DO;
  logic           OE;
  logic [NP*W-1:0] pin_in;
  logic [NP*W-1:0] pin_out;
  logic [NP*W-1:0] ddr;
  logic           irq_n;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gpio_multiport #(.NPORTS(NP), .WIDTH(W), .AW(AWB)) dut (
    .clk     (clk),
    .rst     (rst),
    .cs      (cs),
    .we_n    (we_n),
    .A       (A),
    .DI      (DI),
    .DO      (DO),
    .OE      (OE),
    .pin_in  (pin_in),
    .pin_out (pin_out),
    .ddr     (ddr),
    .irq_n   (irq_n)
  );

  // Reference model state, one byte per port per register.
  logic [7:0]  m_out  [NP];
  logic [7:0]  m_ddr  [NP];
  logic [7:0]  m_ien  [NP];
  logic [7:0]  m_ipol [NP];
  logic [7:0]  m_flag [NP];
  logic [7:0]  m_prev [NP];
  logic [15:0] pin_q [$];
  logic [7:0]  m_do = 8'h00;
  logic        m_oe = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] flat(input logic [7:0] a [NP]);
    logic [15:0] v;
    v = '0;
    for (int p = 0; p < NP; p++) v[p*8 +: 8] = a[p];
    return v;
  endfunction

  function automatic logic exp_irq_n();
    logic any;
    any = 1'b0;
    for (int p = 0; p < NP; p++) any = any | (|(m_flag[p] & m_ien[p]));
    return ~any;
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    logic [7:0]  eff [NP];
    logic [15:0] seen;
    logic [7:0]  hit;
    logic [7:0]  clr;
    int          port;
    int          off;
    bit          wr_acc;
    bit          rd_acc;
    if (rst) begin
      for (int p = 0; p < NP; p++) begin
        m_out[p] = 0; m_ddr[p] = 0; m_ien[p] = 0;
        m_ipol[p] = 0; m_flag[p] = 0; m_prev[p] = 0;
      end
      m_do = 0;
      m_oe = 0;
      pin_q.delete();
      pin_q.push_back(16'h0);
      pin_q.push_back(16'h0);
    end else begin
      seen   = pin_q[0];
      port   = int'(A[4:3]);
      off    = int'(A[2:0]);
      wr_acc = cs && !we_n && (port < NP);
      rd_acc = cs && we_n;
      for (int p = 0; p < NP; p++)
        eff[p] = (m_ddr[p] & m_out[p]) | (~m_ddr[p] & seen[p*8 +: 8]);
      m_oe = rd_acc;
      if (rd_acc) begin
        m_do = 8'h00;
        if (port < NP) begin
          case (off)
            0: m_do = eff[port];
            1: m_do = m_ddr[port];
            2: m_do = m_ien[port];
            3: m_do = m_ipol[port];
            4: m_do = m_flag[port];
            default: m_do = 8'h00;
          endcase
        end
      end
      for (int p = 0; p < NP; p++) begin
        hit = m_ien[p] & ((m_ipol[p] & eff[p] & ~m_prev[p]) |
                          (~m_ipol[p] & ~eff[p] & m_prev[p]));
        clr = (wr_acc && port == p && off == 4) ? DI : 8'h00;
        m_flag[p] = (m_flag[p] & ~clr) | hit;
        m_prev[p] = eff[p];
      end
      if (wr_acc) begin
        case (off)
          0: m_out[port]  = DI;
          1: m_ddr[port]  = DI;
          2: m_ien[port]  = DI;
          3: m_ipol[port] = DI;
          default: ;
        endcase
      end
      void'(pin_q.pop_front());
      pin_q.push_back(pin_in);
    end
  endtask

  task automatic compare_all();
    check("do", DO, m_do);
    check("oe", OE, m_oe);
    check("pin_out", pin_out, flat(m_out));
    check("ddr", ddr, flat(m_ddr));
    check("irq_n", irq_n, exp_irq_n());
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    cs = 1'b1; we_n = 1'b0; A = a; DI = d;
    step();
    cs = 1'b0; we_n = 1'b1;
  endtask

  task automatic rd(input logic [4:0] a);
    cs = 1'b1; we_n = 1'b1; A = a;
    step();
    cs = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cs = 1'b0; we_n = 1'b1; A = '0; DI = '0; pin_in = '0;
    pin_q.push_back(16'h0);
    pin_q.push_back(16'h0);
    idle(2);
    check("rst_irq_n", irq_n, 1'b1);
    check("rst_oe", OE, 1'b0);
    check("rst_do", DO, 8'h00);
    check("rst_pin_out", pin_out, 16'h0000);
    check("rst_ddr", ddr, 16'h0000);
    rst = 1'b0;

    // Mixed direction read-back of port 0.
    pin_in[7:0] = 8'h0C;
    wr(5'd1, 8'hF0);
    wr(5'd0, 8'hA5);
    idle(1);
    rd(5'd0);
    check("t1_data", DO, 8'hAC);
    check("t1_oe", OE, 1'b1);
    idle(1);
    check("t1_oe_idle", OE, 1'b0);
    check("t1_do_hold", DO, 8'hAC);

    // Rising edge on port 1 bit 0, then clear.
    wr(5'd10, 8'h01);
    wr(5'd11, 8'h01);
    pin_in[8] = 1'b1;
    idle(3);
    check("t2_irq", irq_n, 1'b0);
    rd(5'd12);
    check("t2_flag", DO, 8'h01);
    wr(5'd12, 8'h01);
    check("t2_irq_clr", irq_n, 1'b1);

    // Falling-edge polarity on port 0 bit 7; reads leave the flag set.
    wr(5'd1, 8'h00);
    idle(3);
    wr(5'd3, 8'h00);
    wr(5'd2, 8'h80);
    pin_in[7] = 1'b1;
    idle(4);
    rd(5'd4);
    check("t3_no_rise", DO, 8'h00);
    pin_in[7] = 1'b0;
    idle(4);
    rd(5'd4);
    check("t3_fall", DO, 8'h80);
    rd(5'd4);
    check("t3_read_keeps", DO, 8'h80);
    check("t3_irq", irq_n, 1'b0);

    // Edge arriving in the same cycle as a clear of that bit.
    wr(5'd4, 8'h80);
    check("t4_clr", irq_n, 1'b1);
    pin_in[7] = 1'b1;
    idle(4);
    pin_in[7] = 1'b0;
    idle(2);
    wr(5'd4, 8'h80);
    check("t4_set_wins_irq", irq_n, 1'b0);
    rd(5'd4);
    check("t4_set_wins_flag", DO, 8'h80);

    // Reset with a flag pending and a write in flight.
    wr(5'd1, 8'hFF);
    rst = 1'b1; cs = 1'b1; we_n = 1'b0; A = 5'd0; DI = 8'h55;
    step();
    rst = 1'b0; cs = 1'b0; we_n = 1'b1;
    check("t5_pin_out", pin_out, 16'h0000);
    check("t5_ddr", ddr, 16'h0000);
    check("t5_irq", irq_n, 1'b1);
    check("t5_do", DO, 8'h00);
    check("t5_oe", OE, 1'b0);

    // Reserved offsets and out-of-range port index.
    wr(5'd9, 8'h5A);
    rd(5'd9);
    check("t6_ddr1", DO, 8'h5A);
    wr(5'd6, 8'hFF);
    rd(5'd6);
    check("t6_rsv_do", DO, 8'h00);
    check("t6_rsv_oe", OE, 1'b1);
    wr(5'd25, 8'hFF);
    rd(5'd25);
    check("t6_oob_do", DO, 8'h00);
    check("t6_oob_oe", OE, 1'b1);
    check("t6_oob_ddr", ddr, 16'h5A00);
    rd(5'd7);
    check("t6_rsv7_do", DO, 8'h00);

    // Random bus and pad traffic.
    for (int i = 0; i < 800; i++) begin
      rst  = ($urandom_range(0, 63) == 0);
      cs   = $urandom_range(0, 1) == 1;
      we_n = $urandom_range(0, 1) == 1;
      A    = 5'($urandom_range(0, 31));
      DI   = 8'($urandom);
      if ($urandom_range(0, 3) == 0) pin_in = 16'($urandom);
      step();
    end
    rst = 1'b0;
    cs  = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
